// File: rtl/control_unit_pkg.sv
// Control encodings produced by decode and consumed downstream.
package control_unit_pkg;
  typedef enum logic [1:0] {
    MEM_W = 2'd0,
    MEM_H = 2'd1,
    MEM_B = 2'd2
  } memsize_t;

  typedef enum logic [1:0] {
    RS_ALU = 2'd0,
    RS_MEM = 2'd1,
    RS_NPC = 2'd2,
    RS_IMM = 2'd3
  } regsel_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Basic datapath types shared across the core.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
endpackage

// File: rtl/memory_if.sv
// MEM stage <-> data cache and MEM/WB bundle.
interface memory_if;
  import cpu_types_pkg::*;
  import control_unit_pkg::*;

  logic     dmemREN;
  logic     dmemWEN;
  word_t    dmemaddr;
  word_t    dmemstore;
  word_t    dmemload;
  logic     dhit;
  memsize_t memSize;
  logic     memSigned;
  logic     mem_stall;
  logic     misalign_next;
  word_t    dmemload_next;

  modport stage (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    output mem_stall, misalign_next, dmemload_next,
    input  dmemload, dhit, memSize, memSigned
  );

  modport cache (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dmemload, dhit
  );
endinterface

// File: rtl/subword_align.sv
// Byte/halfword lane extraction for loads and lane merge for stores.
module subword_align
  import cpu_types_pkg::*;
  import control_unit_pkg::*;
(
  input  word_t      i_word,
  input  logic [1:0] i_lane,
  input  memsize_t   i_size,
  input  logic       i_signed,
  input  word_t      i_wdat,
  output word_t      o_load,
  output word_t      o_merge
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_bofs;

  always_comb begin
    w_bofs  = {i_lane, 3'b000};
    w_byte  = i_word[w_bofs +: 8];
    w_half  = i_lane[1] ? i_word[31:16] : i_word[15:0];
    o_load  = i_word;
    o_merge = i_wdat;
    case (i_size)
      MEM_B: begin
        o_load  = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merge = i_word;
        o_merge[w_bofs +: 8] = i_wdat[7:0];
      end
      MEM_H: begin
        o_load  = {{16{i_signed & w_half[15]}}, w_half};
        o_merge = i_lane[1] ? {i_wdat[15:0], i_word[15:0]}
                            : {i_word[31:16], i_wdat[15:0]};
      end
      default: begin
        o_load  = i_word;
        o_merge = i_wdat;
      end
    endcase
  end
endmodule

// File: rtl/memory_stage.sv
// MEM stage: data cache sequencing, sub-word load/store, MEM/WB latch.
module memory_stage
  import cpu_types_pkg::*;
  import control_unit_pkg::*;
#(
  parameter bit SUBWORD_EN   = 1'b1,
  parameter bit MISALIGN_CHK = 1'b1
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     ihit,
  input  logic     flush,
  input  logic     valid,
  input  word_t    nPC,
  input  word_t    ALUOut,
  input  word_t    rtdat,
  input  logic     dREN,
  input  logic     dWEN,
  input  logic     regWr,
  input  memsize_t memSize,
  input  logic     memSigned,
  input  regsel_t  regSel,
  input  regbits_t regDst,
  output logic     dmemREN,
  output logic     dmemWEN,
  output word_t    dmemaddr,
  output word_t    dmemstore,
  input  word_t    dmemload,
  input  logic     dhit,
  output logic     mem_stall,
  output logic     valid_next,
  output logic     regWr_next,
  output logic     misalign_next,
  output word_t    nPC_next,
  output word_t    ALUOut_next,
  output word_t    dmemload_next,
  output regsel_t  regSel_next,
  output regbits_t regDst_next
);
  typedef enum logic [2:0] {
    IDLE, RD, RMW_RD, WR, HOLD
  } state_t;

  state_t   r_state;
  state_t   w_state_n;
  memsize_t w_size;
  logic     w_sgn;
  logic     w_ld;
  logic     w_st;
  logic     w_mis;
  logic     w_start;
  logic     w_en;
  word_t    w_ext;
  word_t    w_mrg;
  word_t    r_load;
  word_t    r_merge;

  assign w_size = SUBWORD_EN ? memSize : MEM_W;
  assign w_sgn  = SUBWORD_EN ? memSigned : 1'b0;
  // A simultaneous load/store request is resolved as a load.
  assign w_ld   = valid & dREN;
  assign w_st   = valid & dWEN & ~dREN;
  assign w_mis  = MISALIGN_CHK & (w_ld | w_st) &
                  (((w_size == MEM_W) & (ALUOut[1:0] != 2'b00)) |
                   ((w_size == MEM_H) & ALUOut[0]));
  assign w_start = (w_ld | w_st) & ~w_mis & ~nRST;

  assign mem_stall = (r_state == RD) | (r_state == RMW_RD) |
                     (r_state == WR) | ((r_state == IDLE) & w_start);
  assign w_en      = ihit & ~mem_stall;

  assign dmemREN   = (r_state == RD) | (r_state == RMW_RD);
  assign dmemWEN   = (r_state == WR);
  assign dmemaddr  = {ALUOut[31:2], 2'b00};
  assign dmemstore = (w_size == MEM_W) ? rtdat : r_merge;

  subword_align u_align (
    .i_word   (dmemload),
    .i_lane   (ALUOut[1:0]),
    .i_size   (w_size),
    .i_signed (w_sgn),
    .i_wdat   (rtdat),
    .o_load   (w_ext),
    .o_merge  (w_mrg)
  );

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          if (w_ld)                 w_state_n = RD;
          else if (w_size == MEM_W) w_state_n = WR;
          else                      w_state_n = RMW_RD;
        end
      end
      RD:      if (dhit) w_state_n = HOLD;
      RMW_RD:  if (dhit) w_state_n = WR;
      WR:      if (dhit) w_state_n = HOLD;
      HOLD:    if (w_en) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      r_state <= IDLE;
      r_load  <= '0;
      r_merge <= '0;
    end else begin
      r_state <= w_state_n;
      if ((r_state == RD) & dhit)     r_load  <= w_ext;
      if ((r_state == RMW_RD) & dhit) r_merge <= w_mrg;
    end
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      valid_next    <= 1'b0;
      regWr_next    <= 1'b0;
      misalign_next <= 1'b0;
      nPC_next      <= '0;
      ALUOut_next   <= '0;
      dmemload_next <= '0;
      regSel_next   <= RS_ALU;
      regDst_next   <= '0;
    end else if (w_en) begin
      if (flush | ~valid) begin
        valid_next    <= 1'b0;
        regWr_next    <= 1'b0;
        misalign_next <= 1'b0;
        nPC_next      <= '0;
        ALUOut_next   <= '0;
        dmemload_next <= '0;
        regSel_next   <= RS_ALU;
        regDst_next   <= '0;
      end else begin
        valid_next    <= 1'b1;
        regWr_next    <= regWr & ~w_mis;
        misalign_next <= w_mis;
        nPC_next      <= nPC;
        ALUOut_next   <= ALUOut;
        dmemload_next <= (w_ld & ~w_mis) ? r_load : '0;
        regSel_next   <= regSel;
        regDst_next   <= regDst;
      end
    end
  end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter SUBWORD_EN, default 1, meaning byte/halfword access enabled; 0 treats every access as word.
REQ-002 SHALL have parameter MISALIGN_CHK, default 1, meaning misaligned accesses are suppressed and flagged.
REQ-003 SHALL have ports, in order:
- CLK  in  1  clock.
- nRST  in  1  asynchronous, active-high reset.
- ihit  in  1  pipeline advance qualifier.
- flush  in  1  load a bubble into the MEM/WB latch.
- valid  in  1  MEM-stage instruction present.
- nPC, ALUOut, rtdat  in  32 (word_t) each  next PC, effective address, store data.
- dREN, dWEN, regWr  in  1 each  load, store, register write.
- memSize  in  memsize_t  MEM_W, MEM_H or MEM_B.
- memSigned  in  1  sign-extend sub-word loads.
- regSel  in  regsel_t  writeback source select.
- regDst  in  5 (regbits_t)  destination register.
- dmemREN, dmemWEN  out  1 each  cache read and write strobes.
- dmemaddr, dmemstore  out  32 each  word-aligned cache address, cache store word.
- dmemload  in  32  cache read word.
- dhit  in  1  cache access complete.
- mem_stall  out  1  holds upstream stages.
- valid_next, regWr_next, misalign_next  out  1 each  registered to WB.
- nPC_next, ALUOut_next, dmemload_next  out  32 each  registered to WB.
- regSel_next  out  regsel_t  registered to WB.
- regDst_next  out  5  registered to WB.

Function
REQ-004 SHALL implement FSM states IDLE, RD, RMW_RD, WR, HOLD.
REQ-005 From IDLE with valid & dREN, SHALL go to RD; with dWEN & memSize==MEM_W, to WR; with dWEN sub-word and SUBWORD_EN=1, to RMW_RD.
REQ-006 dREN and dWEN both high SHALL be treated as a load; WEN SHALL be suppressed.
REQ-007 SHALL assert dmemREN in RD and RMW_RD, and dmemWEN in WR; strobes SHALL be combinational from state and never asserted together.
REQ-008 dmemaddr SHALL be {ALUOut[31:2],2'b00} whenever a strobe is asserted.
REQ-009 SHALL hold the state while dhit=0; no timeout.
REQ-010 RD with dhit SHALL capture the extracted and extended load value and go to HOLD.
REQ-011 RMW_RD with dhit SHALL register the merged word and go to WR.
REQ-012 Merging SHALL replace lane ALUOut[1:0] (byte) or ALUOut[1] (half) with rtdat low bits.
REQ-013 WR with dhit SHALL go to HOLD.
REQ-014 dmemstore SHALL be rtdat for word stores and the merge register for sub-word stores.
REQ-015 Load extraction: MEM_B uses byte lane ALUOut[1:0] and MEM_H uses half ALUOut[1]; each SHALL be zero- or sign-extended per memSigned.
REQ-016 mem_stall SHALL equal (state in {RD,RMW_RD,WR}) | (state==IDLE & access about to start).
- mem_stall SHALL be 0 in HOLD and for non-memory or suppressed instructions.
REQ-017 Latch enable SHALL be en = ihit & ~mem_stall.
- On en, the MEM/WB latch SHALL load all *_next outputs, or a bubble if flush=1 or valid=0.
- On en, HOLD SHALL return to IDLE.
REQ-018 A bubble SHALL be all *_next outputs 0.
REQ-019 Misaligned access: MEM_W with ALUOut[1:0]!=0, or MEM_H with ALUOut[0]=1, and MISALIGN_CHK=1.
- SHALL issue no cache strobe and raise no stall.
- SHALL latch misalign_next=1 and regWr_next=0.
REQ-020 flush SHALL NOT abort an in-flight access; the older MEM instruction SHALL complete, then a bubble SHALL be latched.
REQ-021 With SUBWORD_EN=0, memSize and memSigned SHALL be ignored, and RMW_RD SHALL be unreachable.

Reset
REQ-022 nRST high SHALL immediately set state=IDLE, the merge and load-capture registers to 0, and all *_next outputs to 0.
REQ-023 Reset mid-access SHALL drop the access; cache strobes SHALL deassert in the same cycle.

Structure
REQ-024 memsize_t (2-bit enum MEM_W=0, MEM_H=1, MEM_B=2) SHALL live in control_unit_pkg.
REQ-025 The state enum SHALL be local to memory_stage.
REQ-026 Word, register and regsel types SHALL come from cpu_types_pkg and control_unit_pkg.
REQ-027 Lane extract/merge SHALL be one combinational sub-module, subword_align.
REQ-028 memory_if SHALL be extended with the new signals.

Verification
REQ-029 LB signed: ALUOut=0x103, dmemload=0x80FFFFFF, dhit after 2 cycles -> 3 stall cycles, then dmemload_next=0xFFFFFF80.
REQ-030 SH: ALUOut=0x202, rtdat=0x1234, cache word 0xAABBCCDD.
- Expect REN, then WEN at addr 0x200 with dmemstore=0x1234CCDD.
- Never REN and WEN in the same cycle.
REQ-031 LW misaligned: ALUOut=0x101 -> no strobes, mem_stall=0, misalign_next=1, regWr_next=0.
REQ-032 flush=1 during WR with dhit delayed 3 cycles -> the write completes, then a bubble is latched with valid_next=0.
REQ-033 nRST pulse while in RMW_RD -> state IDLE, dmemREN=0 the same cycle, all outputs 0.
REQ-034 ihit=0 for 4 cycles after load dhit -> stays in HOLD, mem_stall=0; the outputs update on the first ihit.
